vdiv_iter: RTL and testbench

- Iterative radix-2 restoring divider for the vector ALU. It produces quotient and remainder, signed or unsigned, one bit per cycle.
- Each step is a shift plus a trial subtract of the divisor.
- Sits beside the add/sub unit in the ALU lane and shares its clock-gating style.
- Valid/ready handshake on both sides; one operation in flight.

---
 rtl/vdiv_pkg.sv | 16 +
 rtl/vdiv_if.sv | 29 ++
 rtl/vdiv_step.sv | 29 ++
 rtl/vdiv_iter.sv | 183 ++++++++++++++++++
 tb/tb_vdiv_iter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/vdiv_pkg.sv
// vdiv_iter shared types: FSM state encoding and result constants.
// Used by vdiv_iter and its step/interface files.
package vdiv_pkg;

   localparam int unsigned MAX_W = 64;
   localparam logic [MAX_W-1:0] QUOT_ONES = '1;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      ITER,
      FIX,
      DONE
   } vdiv_state_e;

endpackage

// File: rtl/vdiv_if.sv
// vdiv_iter handshake bundle: operand request and result response.
// Master drives operands and result acceptance; slave is the divider.
interface vdiv_if #(
   parameter int unsigned DATA_WIDTH = 32
);

   logic                  en_i;
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [DATA_WIDTH-1:0] a_i;
   logic [DATA_WIDTH-1:0] b_i;
   logic                  signed_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] quot_o;
   logic [DATA_WIDTH-1:0] rem_o;
   logic                  dbz_o;

   modport master (
      output en_i, in_valid_i, a_i, b_i, signed_i, out_ready_i,
      input  in_ready_o, out_valid_o, quot_o, rem_o, dbz_o
   );

   modport slave (
      input  en_i, in_valid_i, a_i, b_i, signed_i, out_ready_i,
      output in_ready_o, out_valid_o, quot_o, rem_o, dbz_o
   );

endinterface

// File: rtl/vdiv_step.sv
// One restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module vdiv_step #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH:0]   r_i,
   input  logic [DATA_WIDTH-1:0] q_i,
   input  logic [DATA_WIDTH-1:0] d_i,
   output logic [DATA_WIDTH:0]   r_o,
   output logic [DATA_WIDTH-1:0] q_o
);

   logic [DATA_WIDTH+1:0] r_sh;
   logic [DATA_WIDTH+1:0] diff;

   always_comb begin
      r_sh = {r_i, q_i[DATA_WIDTH-1]};
      diff = r_sh - {2'b00, d_i};
      // Borrow out of the top bit means the trial subtract went negative
      if (diff[DATA_WIDTH+1]) begin
         r_o = r_sh[DATA_WIDTH:0];
         q_o = {q_i[DATA_WIDTH-2:0], 1'b0};
      end else begin
         r_o = diff[DATA_WIDTH:0];
         q_o = {q_i[DATA_WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/vdiv_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned, quotient+remainder.
// Define VDIV_CLK_GATE_EN to clock the datapath from a gated clock.
module vdiv_iter
   import vdiv_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 32,
   localparam int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
   input logic  module_clk_i,
   input logic  rst_ni,
   vdiv_if.slave io
);

   localparam int unsigned W = DATA_WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   vdiv_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;

   logic [W-1:0] a_q, a_d, b_q, b_d;
   logic         sgn_q, sgn_d;
   logic [W:0]   r_q, r_d;
   logic [W-1:0] q_q, q_d;
   logic         negq_q, negq_d, negr_q, negr_d;
   logic         dbz_q, dbz_d;
   logic [W-1:0] quot_q, quot_d, rem_q, rem_d;
   logic         rdbz_q, rdbz_d;

   logic         in_ready;
   logic         accept;
   logic [W-1:0] a_mag, b_mag;
   logic [W:0]   r_nx;
   logic [W-1:0] q_nx;
   logic         dp_clk;

   assign in_ready = rst_ni & io.en_i & (state_q == IDLE);
   assign accept   = io.in_valid_i & in_ready;
   assign a_mag    = (sgn_q && a_q[W-1]) ? -a_q : a_q;
   assign b_mag    = (sgn_q && b_q[W-1]) ? -b_q : b_q;

   vdiv_step #(.DATA_WIDTH(W)) u_step (
      .r_i (r_q),
      .q_i (q_q),
      .d_i (b_mag),
      .r_o (r_nx),
      .q_o (q_nx)
   );

`ifdef VDIV_CLK_GATE_EN
   logic gate_en;
   logic gate_lat;

   assign gate_en = (state_q != IDLE) | accept;

   // Latch-based ICG: enable sampled while clock is low, glitch-free
   always_latch begin
      if (!module_clk_i) gate_lat = gate_en;
   end

   assign dp_clk = module_clk_i & gate_lat;
`else
   assign dp_clk = module_clk_i;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         IDLE: if (accept) state_d = PREP;
         PREP: begin
            cnt_d   = '0;
            state_d = (b_q == '0) ? FIX : ITER;
         end
         ITER: begin
            if (cnt_q == CNT_LAST) state_d = FIX;
            else                   cnt_d   = cnt_q + CNT_W'(1);
         end
         FIX: begin
            state_d     = DONE;
            out_valid_d = 1'b1;
         end
         DONE: begin
            if (io.out_ready_i) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      sgn_d  = sgn_q;
      r_d    = r_q;
      q_d    = q_q;
      negq_d = negq_q;
      negr_d = negr_q;
      dbz_d  = dbz_q;
      quot_d = quot_q;
      rem_d  = rem_q;
      rdbz_d = rdbz_q;
      if (accept) begin
         a_d   = io.a_i;
         b_d   = io.b_i;
         sgn_d = io.signed_i;
      end
      unique case (state_q)
         PREP: begin
            r_d    = '0;
            q_d    = a_mag;
            negq_d = sgn_q & (a_q[W-1] ^ b_q[W-1]);
            negr_d = sgn_q & a_q[W-1];
            dbz_d  = (b_q == '0);
         end
         ITER: begin
            r_d = r_nx;
            q_d = q_nx;
         end
         FIX: begin
            rdbz_d = dbz_q;
            if (dbz_q) begin
               quot_d = QUOT_ONES[W-1:0];
               rem_d  = a_q;
            end else begin
               quot_d = negq_q ? -q_q : q_q;
               rem_d  = negr_q ? -r_q[W-1:0] : r_q[W-1:0];
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge module_clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_ff @(posedge dp_clk or negedge rst_ni) begin
      if (!rst_ni) begin
         a_q    <= '0;
         b_q    <= '0;
         sgn_q  <= 1'b0;
         r_q    <= '0;
         q_q    <= '0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
         dbz_q  <= 1'b0;
         quot_q <= '0;
         rem_q  <= '0;
         rdbz_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         sgn_q  <= sgn_d;
         r_q    <= r_d;
         q_q    <= q_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
         dbz_q  <= dbz_d;
         quot_q <= quot_d;
         rem_q  <= rem_d;
         rdbz_q <= rdbz_d;
      end
   end

   assign io.in_ready_o  = in_ready;
   assign io.out_valid_o = out_valid_q;
   assign io.quot_o      = quot_q;
   assign io.rem_o       = rem_q;
   assign io.dbz_o       = rdbz_q;

endmodule

// File: tb/tb_vdiv_iter.sv
// Self-checking bench for vdiv_iter: vector table, scoreboard queue,
// backpressure, lane enable and mid-operation reset sequences.
module tb_vdiv_iter;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sgn;
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errs   = 0;
   int   checks = 0;
   vec_t sb[$];
   vec_t tbl[12];

   always #5 clk = ~clk;

   vdiv_if #(.DATA_WIDTH(32)) bus ();

   vdiv_iter #(.DATA_WIDTH(32)) dut (
      .module_clk_i (clk),
      .rst_ni       (rst_n),
      .io           (bus)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic s);
      vec_t v;
      v.a = a; v.b = b; v.sgn = s; v.dbz = 1'b0; v.lat = 34;
      if (b == 32'd0) begin
         v.q = 32'hFFFF_FFFF; v.r = a; v.dbz = 1'b1; v.lat = 2;
      end else if (s) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            v.q = a; v.r = 32'd0;
         end else begin
            v.q = $signed(a) / $signed(b);
            v.r = $signed(a) % $signed(b);
         end
      end else begin
         v.q = a / b; v.r = a % b;
      end
      return v;
   endfunction

   task automatic run_op(input vec_t v, input int hold);
      vec_t e;
      int   n;
      @(negedge clk);
      n = 0;
      while (!bus.in_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_idle", 32'(bus.in_ready_o), 32'd1);
      bus.in_valid_i = 1'b1;
      bus.a_i        = v.a;
      bus.b_i        = v.b;
      bus.signed_i   = v.sgn;
      @(posedge clk);
      sb.push_back(v);
      #1;
      bus.in_valid_i = 1'b0;
      bus.a_i        = $urandom();
      bus.b_i        = $urandom();
      bus.signed_i   = ~v.sgn;
      n = 0;
      while (!bus.out_valid_o && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", 32'(n), 32'(v.lat));
      e = sb.pop_front();
      chk("quot", bus.quot_o, e.q);
      chk("rem", bus.rem_o, e.r);
      chk("dbz", 32'(bus.dbz_o), 32'(e.dbz));
      for (int i = 0; i < hold; i++) begin
         bus.in_valid_i = 1'b1;
         bus.a_i        = $urandom();
         bus.b_i        = $urandom();
         @(posedge clk);
         #1;
         chk("bp_valid", 32'(bus.out_valid_o), 32'd1);
         chk("bp_ready", 32'(bus.in_ready_o), 32'd0);
         chk("bp_quot", bus.quot_o, e.q);
         chk("bp_rem", bus.rem_o, e.r);
      end
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready_i = 1'b0;
      chk("valid_drop", 32'(bus.out_valid_o), 32'd0);
      chk("ready_back", 32'(bus.in_ready_o), 32'(bus.en_i));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rs;

      tbl[0]  = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34};
      tbl[1]  = '{32'hFFFF_FFF9, 32'd2, 1'b1,
                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34};
      tbl[2]  = '{32'd7, 32'hFFFF_FFFE, 1'b1,
                  32'hFFFF_FFFD, 32'd1, 1'b0, 34};
      tbl[3]  = '{32'h1234, 32'd0, 1'b0,
                  32'hFFFF_FFFF, 32'h1234, 1'b1, 2};
      tbl[4]  = '{32'h1234, 32'd0, 1'b1,
                  32'hFFFF_FFFF, 32'h1234, 1'b1, 2};
      tbl[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                  32'h8000_0000, 32'd0, 1'b0, 34};
      tbl[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
                  32'd0, 32'h8000_0000, 1'b0, 34};
      tbl[7]  = '{32'hFFFF_FFFF, 32'd2, 1'b0,
                  32'h7FFF_FFFF, 32'd1, 1'b0, 34};
      tbl[8]  = '{32'hFFFF_FF9C, 32'd7, 1'b1,
                  32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34};
      tbl[9]  = '{32'hFFFF_FFF9, 32'd0, 1'b1,
                  32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 2};
      tbl[10] = '{32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0, 34};
      tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
                  32'd1, 32'd0, 1'b0, 34};

      bus.en_i        = 1'b1;
      bus.in_valid_i  = 1'b0;
      bus.a_i         = '0;
      bus.b_i         = '0;
      bus.signed_i    = 1'b0;
      bus.out_ready_i = 1'b0;

      #12;
      chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      chk("rst_quot", bus.quot_o, 32'd0);
      chk("rst_rem", bus.rem_o, 32'd0);
      chk("rst_dbz", 32'(bus.dbz_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(bus.in_ready_o), 32'd1);

      // lane disabled: request must be ignored
      bus.en_i = 1'b0;
      #1;
      chk("en_low_ready", 32'(bus.in_ready_o), 32'd0);
      bus.in_valid_i = 1'b1;
      bus.a_i        = 32'd50;
      bus.b_i        = 32'd5;
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid_i = 1'b0;
      bus.en_i       = 1'b1;
      #1;
      chk("en_low_no_accept", 32'(bus.in_ready_o), 32'd1);

      for (int i = 0; i < 12; i++) run_op(tbl[i], 0);

      run_op(tbl[0], 5);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom();
         rb = $urandom() >> $urandom_range(0, 31);
         rs = 1'($urandom_range(0, 1));
         run_op(model(ra, rb, rs), 0);
      end

      run_op(tbl[0], 0);

      // reset in the middle of iteration 10
      @(negedge clk);
      bus.in_valid_i = 1'b1;
      bus.a_i        = 32'd1000;
      bus.b_i        = 32'd3;
      bus.signed_i   = 1'b0;
      @(posedge clk);
      sb.push_back(model(32'd1000, 32'd3, 1'b0));
      #1;
      bus.in_valid_i = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
      chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
      chk("mid_rst_quot", bus.quot_o, 32'd0);
      chk("mid_rst_rem", bus.rem_o, 32'd0);
      chk("mid_rst_dbz", 32'(bus.dbz_o), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_idle", 32'(bus.in_ready_o), 32'd1);
      run_op(model(32'd9, 32'd3, 1'b0), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
